concat_unpack: RTL

- Inverse of the lane packer that ORs shifted 4-bit and 6-bit compute fields into 24-bit lanes of a 384-bit concat/nonconcat bus.
- Accepts one packed 384-bit word plus per-lane shift amounts (derived from filter weights) over a valid/ready handshake.
- Walks the 16 lanes one per handshake and recovers the original field values (field A 4-bit, field B 6-bit), flagging malformed lanes.
- Sits on the readback path between the PIM array output buffer and the accumulation/verification logic.

---
 rtl/concat_unpack_if.sv | 35 +++
 rtl/concat_unpack.sv | 99 +++++++++
 2 files changed

// File: rtl/concat_unpack_if.sv
// Handshake bundle for concat_unpack: packed-word request side and per-lane result side.
// The master drives the word and consumes results; the slave is the unpacker.
interface concat_unpack_if #(
    parameter int LANES  = 16,
    parameter int LANE_W = 24,
    parameter int A_W    = 4,
    parameter int B_W    = 6,
    parameter int SH_W   = 5
);
    localparam int IDX_W = $clog2(LANES);

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*LANE_W-1:0] in_word;
    logic                    in_concat;
    logic [LANES*SH_W-1:0]   in_shift_a;
    logic [LANES*SH_W-1:0]   in_shift_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        out_lane_idx;
    logic [A_W-1:0]          out_field_a;
    logic [B_W-1:0]          out_field_b;
    logic                    out_err;
    logic                    out_last;

    modport master (
        output in_valid, in_word, in_concat, in_shift_a, in_shift_b, out_ready,
        input  in_ready, out_valid, out_lane_idx, out_field_a, out_field_b, out_err, out_last
    );

    modport slave (
        input  in_valid, in_word, in_concat, in_shift_a, in_shift_b, out_ready,
        output in_ready, out_valid, out_lane_idx, out_field_a, out_field_b, out_err, out_last
    );
endinterface

// File: rtl/concat_unpack.sv
// Unpacks a 16-lane packed word one lane per handshake, recovering the shifted A/B
// fields and flagging lanes whose shifts run off the lane or make the fields collide.
module concat_unpack #(
    parameter int LANES  = 16,
    parameter int LANE_W = 24,
    parameter int A_W    = 4,
    parameter int B_W    = 6,
    parameter int SH_W   = 5
) (
    input logic             clk,
    input logic             reset,
    concat_unpack_if.slave  bus
);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic {IDLE, UNPACK} state_t;

    state_t                         state, stateNxt;
    logic [IDX_W-1:0]               idx, idxNxt;
    logic                           load;
    logic [LANES-1:0][LANE_W-1:0]   wordBuf;
    logic [LANES-1:0][SH_W-1:0]     shABuf, shBBuf;
    logic                           concatBuf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            wordBuf   <= '0;
            shABuf    <= '0;
            shBBuf    <= '0;
            concatBuf <= 1'b0;
        end else begin
            state <= stateNxt;
            idx   <= idxNxt;
            if (load) begin
                wordBuf   <= bus.in_word;
                shABuf    <= bus.in_shift_a;
                shBBuf    <= bus.in_shift_b;
                concatBuf <= bus.in_concat;
            end
        end
    end

    always_comb begin
        stateNxt = state;
        idxNxt   = idx;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load     = 1'b1;
                    idxNxt   = '0;
                    stateNxt = UNPACK;
                end
            end
            UNPACK: begin
                if (bus.out_ready) begin
                    if (idx == IDX_W'(LANES - 1)) begin
                        idxNxt   = '0;
                        stateNxt = IDLE;
                    end else begin
                        idxNxt = idx + IDX_W'(1);
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Lane decode is purely combinational on the held buffer, so a stall keeps outputs stable.
    logic [LANE_W-1:0] lane;
    logic [SH_W-1:0]   sa, sb;
    logic [SH_W:0]     saTop, sbTop;
    logic [LANE_W-1:0] shA, shB;
    logic              errRange, errOverlap, active;

    always_comb begin
        lane       = wordBuf[idx];
        sa         = shABuf[idx];
        sb         = shBBuf[idx];
        saTop      = {1'b0, sa} + (SH_W+1)'(A_W - 1);
        sbTop      = {1'b0, sb} + (SH_W+1)'(B_W - 1);
        shA        = lane >> sa;
        shB        = lane >> sb;
        errRange   = (sa > SH_W'(LANE_W - A_W)) ||
                     (concatBuf && (sb > SH_W'(LANE_W - B_W)));
        errOverlap = concatBuf && ({1'b0, sa} <= sbTop) && ({1'b0, sb} <= saTop);
        active     = (state == UNPACK);
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = active;
    assign bus.out_lane_idx = active ? idx : '0;
    assign bus.out_field_a  = active ? shA[A_W-1:0] : '0;
    assign bus.out_field_b  = (active && concatBuf) ? shB[B_W-1:0] : '0;
    assign bus.out_err      = active && (errRange || errOverlap);
    assign bus.out_last     = active && (idx == IDX_W'(LANES - 1));
endmodule
